tcdm_bank_arb_resp_demux_varlat: RTL and testbench

Bank-side responder for the variable-latency TCDM crossbar. It arbitrates up to NumIn master requests onto one variable-latency bank port using round-robin. It keeps exactly one transaction in flight per bank and steers the bank's valid/read-data back to the master that was granted. It is the slave-end counterpart of the per-master address decoder/response mux: same req/gnt/vld handshake, no outstanding and no out-of-order transactions.

---
 rtl/tcdm_bank_arb_resp_demux_varlat_if.sv | 33 +++
 rtl/tcdm_bank_arb_resp_demux_varlat.sv | 128 ++++++++++++
 tb/tb_tcdm_bank_arb_resp_demux_varlat.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/tcdm_bank_arb_resp_demux_varlat_if.sv
`default_nettype none
// ============================================================================
// Module : tcdm_bank_arb_resp_demux_varlat_if
// Brief  : Master-side and bank-side req/gnt/vld bundle of the bank responder.
// Rev    : 1.0
// ============================================================================
interface tcdm_bank_arb_resp_demux_varlat_if #(
    parameter int unsigned NumIn         = 32,
    parameter int unsigned ReqDataWidth  = 32,
    parameter int unsigned RespDataWidth = 32
);
    logic [NumIn-1:0]                    req_i;
    logic [NumIn-1:0][ReqDataWidth-1:0]  data_i;
    logic [NumIn-1:0]                    gnt_o;
    logic [NumIn-1:0]                    vld_o;
    logic [NumIn-1:0][RespDataWidth-1:0] rdata_o;
    logic                                req_o;
    logic [ReqDataWidth-1:0]             data_o;
    logic                                gnt_i;
    logic                                vld_i;
    logic [RespDataWidth-1:0]            rdata_i;

    modport slave (
        input  req_i, data_i, gnt_i, vld_i, rdata_i,
        output gnt_o, vld_o, rdata_o, req_o, data_o
    );

    modport master (
        output req_i, data_i, gnt_i, vld_i, rdata_i,
        input  gnt_o, vld_o, rdata_o, req_o, data_o
    );
endinterface
`default_nettype wire

// File: rtl/tcdm_bank_arb_resp_demux_varlat.sv
`default_nettype none
// ============================================================================
// Module : tcdm_bank_arb_resp_demux_varlat
// Brief  : Round-robin bank arbiter, one transaction in flight, response demux.
//          Optional macro TCDM_BANK_ARB_RESP_REG_EN registers vld_o/rdata_o.
// Rev    : 1.0
// ============================================================================
module tcdm_bank_arb_resp_demux_varlat #(
    parameter int unsigned NumIn         = 32,
    parameter int unsigned ReqDataWidth  = 32,
    parameter int unsigned RespDataWidth = 32
) (
    input  wire logic                         clk_i,
    input  wire logic                         rst_ni,
    tcdm_bank_arb_resp_demux_varlat_if.slave  bus
);
    localparam int unsigned LogNumIn = (NumIn > 1) ? $clog2(NumIn) : 1;
    localparam logic [LogNumIn-1:0] LastIdx = LogNumIn'(NumIn - 1);
    localparam logic [LogNumIn:0]   NumInW  = (LogNumIn + 1)'(NumIn);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [LogNumIn-1:0] owner_q, owner_d;
    logic [LogNumIn-1:0] rr_q, rr_d;
    logic [LogNumIn-1:0] winner;
    logic [LogNumIn:0]   cand;
    logic                found;
    logic                arb_allowed;
    logic                handshake;
    logic                resp_fire;
    logic [NumIn-1:0]    vld_comb;

    // First requester at or after rr_q, wrapping; rr_q itself when nobody asks.
    always_comb begin
        winner = rr_q;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned k = 0; k < NumIn; k++) begin
            cand = {1'b0, rr_q} + (LogNumIn + 1)'(k);
            if (cand >= NumInW) begin
                cand = cand - NumInW;
            end
            if (!found && bus.req_i[cand[LogNumIn-1:0]]) begin
                winner = cand[LogNumIn-1:0];
                found  = 1'b1;
            end
        end
    end

    // The bank is free when idle, or when its response retires this cycle.
    assign arb_allowed = (state_q == IDLE) || bus.vld_i;
    assign resp_fire   = (state_q == BUSY) && bus.vld_i;
    assign handshake   = bus.req_o && bus.gnt_i;
    assign bus.req_o   = arb_allowed && (|bus.req_i);
    assign bus.data_o  = bus.data_i[winner];

    always_comb begin
        bus.gnt_o = '0;
        if (arb_allowed) begin
            bus.gnt_o[winner] = bus.gnt_i;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        if (handshake) begin
            state_d = BUSY;
            owner_d = winner;
            rr_d    = (winner == LastIdx) ? '0 : winner + LogNumIn'(1);
        end else if (resp_fire) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        vld_comb = '0;
        if (resp_fire) begin
            vld_comb[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

`ifdef TCDM_BANK_ARB_RESP_REG_EN
    logic [NumIn-1:0]         vld_q, vld_d;
    logic [RespDataWidth-1:0] rdata_q, rdata_d;

    // vld_d follows the combinational pulse, so vld_o never lasts past one cycle.
    always_comb begin
        vld_d   = vld_comb;
        rdata_d = resp_fire ? bus.rdata_i : rdata_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q   <= '0;
            rdata_q <= '0;
        end else begin
            vld_q   <= vld_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.vld_o   = vld_q;
    assign bus.rdata_o = {NumIn{rdata_q}};
`else
    assign bus.vld_o   = vld_comb;
    assign bus.rdata_o = {NumIn{bus.rdata_i}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_tcdm_bank_arb_resp_demux_varlat.sv
`default_nettype none
// ============================================================================
// Module : tb_tcdm_bank_arb_resp_demux_varlat
// Brief  : Directed bench for the bank arbiter / response demux, NumIn=4.
// Rev    : 1.0
// ============================================================================
module tb_tcdm_bank_arb_resp_demux_varlat;
    localparam int N = 4;
`ifdef TCDM_BANK_ARB_RESP_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    tcdm_bank_arb_resp_demux_varlat_if #(
        .NumIn(N), .ReqDataWidth(32), .RespDataWidth(32)
    ) bus ();

    tcdm_bank_arb_resp_demux_varlat #(
        .NumIn(N), .ReqDataWidth(32), .RespDataWidth(32)
    ) u_dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_i   = '0;
        bus.gnt_i   = 1'b0;
        bus.vld_i   = 1'b0;
        bus.rdata_i = '0;
        for (int i = 0; i < N; i++) bus.data_i[i] = 32'hD000_0000 + 32'(i);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] rd0;
        rst_n = 1'b0;
        clear_inputs();
        next_cycle();
        next_cycle();
        bus.req_i = 4'b0110;
        #3;
        rd0 = bus.rdata_o[0];
        n_tests++; if (bus.req_o !== 1'b1) begin n_fail++; $display("FAIL rst_req_o got=%b exp=1", bus.req_o); end
        n_tests++; if (bus.gnt_o !== 4'b0000) begin n_fail++; $display("FAIL rst_gnt_o got=%b exp=0000", bus.gnt_o); end
        n_tests++; if (bus.vld_o !== 4'b0000) begin n_fail++; $display("FAIL rst_vld_o got=%b exp=0000", bus.vld_o); end
        n_tests++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got=%h exp=0", rd0); end
        bus.gnt_i = 1'b1;
        #1;
        n_tests++; if (bus.gnt_o !== 4'b0010) begin n_fail++; $display("FAIL rst_gnt_idle got=%b exp=0010", bus.gnt_o); end
        next_cycle();
        rst_n = 1'b1;
        clear_inputs();
    endtask

    task automatic test_basic();
        logic [31:0] rd1;
        do_reset();
        bus.req_i = 4'b0110; bus.gnt_i = 1'b1;
        #3;
        n_tests++; if (bus.gnt_o !== 4'b0010) begin n_fail++; $display("FAIL s1_gnt got=%b exp=0010", bus.gnt_o); end
        n_tests++; if (bus.data_o !== 32'hD000_0001) begin n_fail++; $display("FAIL s1_data got=%h exp=d0000001", bus.data_o); end
        n_tests++; if (bus.vld_o !== 4'b0000) begin n_fail++; $display("FAIL s1_vld_early got=%b exp=0000", bus.vld_o); end
        next_cycle();
        bus.req_i = '0; bus.gnt_i = 1'b0; bus.vld_i = 1'b1; bus.rdata_i = 32'hCAFE_0001;
        #3;
        rd1 = bus.rdata_o[1];
        n_tests++; if (bus.vld_o !== ((LAT == 0) ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL s1_vld got=%b lat=%0d", bus.vld_o, LAT); end
        n_tests++; if (rd1 !== ((LAT == 0) ? 32'hCAFE_0001 : 32'h0)) begin n_fail++; $display("FAIL s1_rdata got=%h lat=%0d", rd1, LAT); end
        next_cycle();
        bus.vld_i = 1'b0; bus.rdata_i = '0;
        #3;
        rd1 = bus.rdata_o[1];
        n_tests++; if (bus.vld_o !== ((LAT == 1) ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL s1_vld_late got=%b lat=%0d", bus.vld_o, LAT); end
        n_tests++; if (rd1 !== ((LAT == 1) ? 32'hCAFE_0001 : 32'h0)) begin n_fail++; $display("FAIL s1_rdata_late got=%h lat=%0d", rd1, LAT); end
        // Pointer should now sit at 2.
        bus.req_i = 4'b1111; bus.gnt_i = 1'b1;
        #1;
        n_tests++; if (bus.gnt_o !== 4'b0100) begin n_fail++; $display("FAIL s1_rr got=%b exp=0100", bus.gnt_o); end
        n_tests++; if (bus.data_o !== 32'hD000_0002) begin n_fail++; $display("FAIL s1_rr_data got=%h exp=d0000002", bus.data_o); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  exp_gnt, exp_vld;
        logic [31:0] exp_rd, rd2;
        do_reset();
        bus.req_i = 4'b1111; bus.gnt_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.vld_i   = (k > 0);
            bus.rdata_i = 32'hB0 + 32'(k);
            #3;
            exp_gnt = 4'b0001 << (k % 4);
            exp_vld = (k >= 1 + LAT) ? (4'b0001 << ((k - 1 - LAT) % 4)) : 4'b0000;
            exp_rd  = (LAT == 0) ? (32'hB0 + 32'(k)) : ((k >= 2) ? (32'hB0 + 32'(k - 1)) : 32'h0);
            rd2     = bus.rdata_o[2];
            n_tests++; if (bus.gnt_o !== exp_gnt) begin n_fail++; $display("FAIL b2b_gnt k=%0d got=%b exp=%b", k, bus.gnt_o, exp_gnt); end
            n_tests++; if (bus.vld_o !== exp_vld) begin n_fail++; $display("FAIL b2b_vld k=%0d got=%b exp=%b", k, bus.vld_o, exp_vld); end
            n_tests++; if (rd2 !== exp_rd) begin n_fail++; $display("FAIL b2b_rdata k=%0d got=%h exp=%h", k, rd2, exp_rd); end
            next_cycle();
        end
        bus.req_i = '0; bus.gnt_i = 1'b0; bus.vld_i = 1'b1;
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_stall();
        do_reset();
        bus.req_i = 4'b0001; bus.gnt_i = 1'b1;
        #3;
        n_tests++; if (bus.gnt_o !== 4'b0001) begin n_fail++; $display("FAIL stall_first_gnt got=%b exp=0001", bus.gnt_o); end
        next_cycle();
        bus.req_i = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            #3;
            n_tests++; if (bus.gnt_o !== 4'b0000) begin n_fail++; $display("FAIL stall_gnt c=%0d got=%b exp=0000", c, bus.gnt_o); end
            n_tests++; if (bus.req_o !== 1'b0) begin n_fail++; $display("FAIL stall_req c=%0d got=%b exp=0", c, bus.req_o); end
            next_cycle();
        end
        bus.vld_i = 1'b1; bus.rdata_i = 32'h5A5A_0000;
        #3;
        n_tests++; if (bus.gnt_o !== 4'b1000) begin n_fail++; $display("FAIL stall_release_gnt got=%b exp=1000", bus.gnt_o); end
        n_tests++; if (bus.req_o !== 1'b1) begin n_fail++; $display("FAIL stall_release_req got=%b exp=1", bus.req_o); end
        n_tests++; if (bus.vld_o !== ((LAT == 0) ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL stall_vld0 got=%b lat=%0d", bus.vld_o, LAT); end
        next_cycle();
        bus.req_i = '0; bus.rdata_i = 32'h5A5A_0003;
        #3;
        n_tests++; if (bus.vld_o !== ((LAT == 0) ? 4'b1000 : 4'b0001)) begin n_fail++; $display("FAIL stall_vld3 got=%b lat=%0d", bus.vld_o, LAT); end
        next_cycle();
        bus.vld_i = 1'b0;
        #3;
        n_tests++; if (bus.vld_o !== ((LAT == 1) ? 4'b1000 : 4'b0000)) begin n_fail++; $display("FAIL stall_vld_tail got=%b lat=%0d", bus.vld_o, LAT); end
        next_cycle();
        #3;
        n_tests++; if (bus.vld_o !== 4'b0000) begin n_fail++; $display("FAIL stall_vld_hold got=%b exp=0000", bus.vld_o); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_idle_vld();
        do_reset();
        bus.vld_i = 1'b1; bus.rdata_i = 32'h7777_7777;
        #3;
        n_tests++; if (bus.vld_o !== 4'b0000) begin n_fail++; $display("FAIL idle_vld got=%b exp=0000", bus.vld_o); end
        n_tests++; if (bus.req_o !== 1'b0) begin n_fail++; $display("FAIL idle_req got=%b exp=0", bus.req_o); end
        next_cycle();
        bus.vld_i = 1'b0;
        #3;
        n_tests++; if (bus.vld_o !== 4'b0000) begin n_fail++; $display("FAIL idle_vld_next got=%b exp=0000", bus.vld_o); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req_i = 4'b0100; bus.gnt_i = 1'b1;
        #3;
        n_tests++; if (bus.gnt_o !== 4'b0100) begin n_fail++; $display("FAIL rmid_gnt got=%b exp=0100", bus.gnt_o); end
        next_cycle();
        rst_n = 1'b0; bus.req_i = '0; bus.gnt_i = 1'b0;
        next_cycle();
        rst_n = 1'b1; bus.vld_i = 1'b1; bus.rdata_i = 32'h1234_5678;
        #3;
        n_tests++; if (bus.vld_o !== 4'b0000) begin n_fail++; $display("FAIL rmid_vld got=%b exp=0000", bus.vld_o); end
        next_cycle();
        bus.vld_i = 1'b0;
        #3;
        n_tests++; if (bus.vld_o !== 4'b0000) begin n_fail++; $display("FAIL rmid_vld_next got=%b exp=0000", bus.vld_o); end
        bus.req_i = 4'b1111; bus.gnt_i = 1'b1;
        #1;
        n_tests++; if (bus.gnt_o !== 4'b0001) begin n_fail++; $display("FAIL rmid_rr got=%b exp=0001", bus.gnt_o); end
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_idle_vld();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
